// File: rtl/rv32e_pkg.sv
// Shared RV32E definitions: machine width, opcode/funct fields, canonical NOP
// and a word-alignment helper. Decode and the ROM images use the same constants.
package rv32e_pkg;

  localparam int XLEN = 32;

  // Major opcodes
  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

  // funct3 encodings (OP / OP-IMM)
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // funct7 encodings
  localparam logic [6:0] F7_BASE = 7'b000_0000;
  localparam logic [6:0] F7_ALT  = 7'b010_0000;

  // ADDI x0, x0, 0
  localparam logic [XLEN-1:0] I_NOP = 32'h0000_0013;

  // Clear the two byte-offset bits of an address.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {pc, instr} pairs between the PC register and decode.
// Flush empties it in one cycle and overrides any same-cycle push/pop.
// Storage is not reset; only pointers and occupancy are.
module fetch_queue
  import rv32e_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  logic [XLEN-1:0] push_pc,
  input  logic [XLEN-1:0] push_instr,
  output logic            full,
  output logic            empty,
  output logic [XLEN-1:0] head_pc,
  output logic [XLEN-1:0] head_instr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  pc_mem    [DEPTH];
  logic [XLEN-1:0]  instr_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];

  // Entry storage: written on every accepted push, never reset.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem[wr_ptr]    <= push_pc;
      instr_mem[wr_ptr] <= push_instr;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32E fetch stage: owns the PC, addresses the combinational program ROM and
// queues {pc, instr} pairs toward decode over a valid/ready handshake.
// Optional build macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect raises a
// sticky fetch_fault_o and halts fetching until an aligned redirect or reset.
// Without it, redirect targets are forced word-aligned and no fault is raised.
module instr_fetch_unit
  import rv32e_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
  parameter int              QUEUE_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] rom_addr_o,
  input  logic [XLEN-1:0] rom_data_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  output logic            fetch_fault_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] redirect_target;
  logic            halt;
  logic            push;
  logic            pop;
  logic            q_full;
  logic            q_empty;
  logic [XLEN-1:0] head_pc;
  logic [XLEN-1:0] head_instr;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q;

  assign redirect_target = redirect_pc_i;
  assign halt            = fault_q;
  assign fetch_fault_o   = fault_q;

  // Sticky fault: every redirect re-evaluates it, so an aligned one clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (redirect_i) begin
      fault_q <= |redirect_pc_i[1:0];
    end
  end
`else
  assign redirect_target = align_word(redirect_pc_i);
  assign halt            = 1'b0;
  assign fetch_fault_o   = 1'b0;
`endif

  // A redirect drops any same-cycle handshake; the queue flush discards it anyway.
  assign pop  = instr_valid_o & instr_ready_i & ~redirect_i;
  // Push into a free slot, or into the slot a same-cycle pop is vacating.
  assign push = ~redirect_i & ~halt & (~q_full | pop);

  assign rom_addr_o    = pc_q;
  assign instr_valid_o = ~q_empty;
  assign instr_o       = q_empty ? I_NOP : head_instr;
  assign instr_pc_o    = q_empty ? '0    : head_pc;

  // PC register: reset, then redirect, then sequential advance on each push.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (redirect_i) begin
      pc_q <= redirect_target;
    end else if (push) begin
      pc_q <= pc_q + 32'd4;
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fetch_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_i),
    .push_pc    (pc_q),
    .push_instr (rom_data_i),
    .full       (q_full),
    .empty      (q_empty),
    .head_pc    (head_pc),
    .head_instr (head_instr)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized
// traffic against a queue-based behavioural model of the fetch stage.
// Honours FETCH_MISALIGN_TRAP_EN the same way the design does.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          QD       = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid_o;
  logic        ready = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        fetch_fault_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [63:0] m_q[$];
  logic [31:0] m_pc = RESET_PC;
  logic        m_fault = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0010_6393;
    return a ^ {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign rom_data_i = rom_word(rom_addr_o);

  instr_fetch_unit #(
    .RESET_PC    (RESET_PC),
    .QUEUE_DEPTH (QD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rom_addr_o    (rom_addr_o),
    .rom_data_i    (rom_data_i),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (ready),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .fetch_fault_o (fetch_fault_o)
  );

  // Advance one clock; the model applies the same inputs the DUT saw at the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_q.delete();
      m_pc    = RESET_PC;
      m_fault = 1'b0;
    end else if (redirect) begin
      m_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
      m_fault = (redirect_pc % 4) != 0;
      m_pc    = redirect_pc;
`else
      m_pc    = redirect_pc - (redirect_pc % 4);
`endif
    end else begin
      if (m_q.size() != 0 && ready) void'(m_q.pop_front());
      if (!m_fault && m_q.size() < QD) begin
        m_q.push_back({m_pc, rom_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redirect = 1'b0; tick(); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect = 1'b1; redirect_pc = 32'h44; ready = 1'b1;
    tick(); tick();
    checks++; if (rom_addr_o !== RESET_PC) begin errors++; $display("FAIL reset_addr got %h exp %h", rom_addr_o, RESET_PC); end
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid_o); end
    checks++; if (instr_o !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", instr_o, NOP); end
    checks++; if (instr_pc_o !== 32'h0) begin errors++; $display("FAIL reset_ipc got %h exp 0", instr_pc_o); end
    checks++; if (fetch_fault_o !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", fetch_fault_o); end
    rst_n = 1'b1; redirect = 1'b0;
    checks++; if (rom_addr_o !== 32'h0 || instr_valid_o !== 1'b0) begin errors++; $display("FAIL first_cycle got addr %h valid %b exp 0/0", rom_addr_o, instr_valid_o); end
    tick();
    checks++; if (instr_valid_o !== 1'b1 || instr_o !== 32'h0010_6393 || instr_pc_o !== 32'h0) begin
      errors++; $display("FAIL first_instr got v%b %h @%h exp v1 00106393 @0", instr_valid_o, instr_o, instr_pc_o);
    end
  endtask

  task automatic test_stream();
    for (int i = 1; i < 12; i++) begin
      tick();
      checks++;
      if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'(4 * i) || instr_o !== rom_word(32'(4 * i))) begin
        errors++; $display("FAIL stream[%0d] got v%b %h @%h exp v1 %h @%h", i, instr_valid_o, instr_o, instr_pc_o, rom_word(32'(4 * i)), 4 * i);
      end
    end
  endtask

  task automatic test_stall();
    int n = 0;
    do_reset();
    ready = 1'b1;
    while (!(instr_valid_o === 1'b1 && instr_pc_o === 32'h8) && n < 20) begin tick(); n++; end
    checks++; if (n >= 20) begin errors++; $display("FAIL stall_reach_pc8 got timeout exp head pc 8"); end
    ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (rom_addr_o !== 32'h10 || instr_valid_o !== 1'b1 || instr_pc_o !== 32'h8 || instr_o !== rom_word(32'h8)) begin
        errors++; $display("FAIL stall[%0d] got addr %h v%b @%h %h exp addr 10 v1 @8 %h", c, rom_addr_o, instr_valid_o, instr_pc_o, instr_o, rom_word(32'h8));
      end
    end
    ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'(8 + 4 * k)) begin
        errors++; $display("FAIL release[%0d] got v%b @%h exp v1 @%h", k, instr_valid_o, instr_pc_o, 8 + 4 * k);
      end
      tick();
    end
  endtask

  task automatic test_redirect_full();
    checks++; if (m_q.size() != QD || instr_valid_o !== 1'b1) begin errors++; $display("FAIL redir_precond got v%b exp full queue", instr_valid_o); end
    ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h28;
    tick();
    redirect = 1'b0;
    checks++; if (instr_valid_o !== 1'b0 || rom_addr_o !== 32'h28) begin errors++; $display("FAIL redir_next got v%b addr %h exp v0 addr 28", instr_valid_o, rom_addr_o); end
    tick();
    checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h28 || instr_o !== rom_word(32'h28)) begin
      errors++; $display("FAIL redir_first got v%b @%h exp v1 @28", instr_valid_o, instr_pc_o);
    end
  endtask

  task automatic test_redirect_reset();
    redirect = 1'b1; redirect_pc = 32'h30; rst_n = 1'b0;
    tick();
    redirect = 1'b0; rst_n = 1'b1;
    checks++; if (rom_addr_o !== RESET_PC || instr_valid_o !== 1'b0 || fetch_fault_o !== 1'b0) begin
      errors++; $display("FAIL redir_reset got addr %h v%b f%b exp %h v0 f0", rom_addr_o, instr_valid_o, fetch_fault_o, RESET_PC);
    end
  endtask

  task automatic test_misalign();
    ready = 1'b1; tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h22;
    tick();
    redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int c = 0; c < 3; c++) begin
      checks++; if (fetch_fault_o !== 1'b1 || instr_valid_o !== 1'b0) begin errors++; $display("FAIL misalign_hold[%0d] got f%b v%b exp f1 v0", c, fetch_fault_o, instr_valid_o); end
      tick();
    end
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    checks++; if (fetch_fault_o !== 1'b0 || rom_addr_o !== 32'h40) begin errors++; $display("FAIL misalign_clear got f%b addr %h exp f0 addr 40", fetch_fault_o, rom_addr_o); end
    tick();
    checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h40) begin errors++; $display("FAIL misalign_resume got v%b @%h exp v1 @40", instr_valid_o, instr_pc_o); end
`else
    checks++; if (fetch_fault_o !== 1'b0 || rom_addr_o !== 32'h20 || instr_valid_o !== 1'b0) begin
      errors++; $display("FAIL misalign_align got f%b addr %h v%b exp f0 addr 20 v0", fetch_fault_o, rom_addr_o, instr_valid_o);
    end
    tick();
    checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h20 || fetch_fault_o !== 1'b0) begin
      errors++; $display("FAIL misalign_fetch got v%b @%h f%b exp v1 @20 f0", instr_valid_o, instr_pc_o, fetch_fault_o);
    end
`endif
  endtask

  task automatic test_random();
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    // Start near the top of the address space so the PC wraps.
    rst_n = 1'b1; ready = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFF4;
    tick();
    redirect = 1'b0;
    for (int c = 0; c < 600; c++) begin
      exp_instr = (m_q.size() != 0) ? m_q[0][31:0]  : NOP;
      exp_pc    = (m_q.size() != 0) ? m_q[0][63:32] : 32'h0;
      checks++;
      if (instr_valid_o !== (m_q.size() != 0) || instr_o !== exp_instr ||
          (m_q.size() != 0 && instr_pc_o !== exp_pc)) begin
        errors++; $display("FAIL rand_head[%0d] got v%b %h @%h exp v%b %h @%h", c, instr_valid_o, instr_o, instr_pc_o, m_q.size() != 0, exp_instr, exp_pc);
      end
      checks++;
      if (rom_addr_o !== m_pc || fetch_fault_o !== m_fault) begin
        errors++; $display("FAIL rand_pc[%0d] got addr %h f%b exp addr %h f%b", c, rom_addr_o, fetch_fault_o, m_pc, m_fault);
      end
      rst_n       = ($urandom_range(0, 79) != 0);
      redirect    = ($urandom_range(0, 11) == 0);
      redirect_pc = $urandom & 32'h0000_03FF;
      ready       = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst_n = 1'b1; redirect = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_redirect_reset();
    test_misalign();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
